// File: rtl/bat_input_ctrl.sv
// Per-bat input mapper: turns keyboard held-state events and absolute mouse
// position samples into a signed per-frame move for each bat. Moves are
// published once per frame, in the cycle after each vsync rising edge.
module bat_input_ctrl #(
  parameter int unsigned NUM_BATS      = 2,
  parameter int unsigned POS_W         = 8,
  parameter int unsigned MOVE_W        = 9,
  parameter int unsigned KEY_STEP      = 4,
  parameter int unsigned WARMUP_FRAMES = 7
) (
  input  logic                         fclk,
  input  logic                         game_reset,
  input  logic                         vsync,
  input  logic [NUM_BATS-1:0]          key_stb,
  input  logic [NUM_BATS-1:0]          key_up,
  input  logic [NUM_BATS-1:0]          key_dn,
  input  logic [NUM_BATS-1:0]          pos_stb,
  input  logic [NUM_BATS*POS_W-1:0]    pos_val,
  output logic                         frame_stb,
  output logic [NUM_BATS-1:0]          bat_human,
  output logic [NUM_BATS*MOVE_W-1:0]   bat_move
);

  typedef enum logic {ModeKey, ModeMouse} mode_e;

  localparam logic [MOVE_W-1:0] KeyStepPos = MOVE_W'(KEY_STEP);
  localparam logic [MOVE_W-1:0] KeyStepNeg = MOVE_W'(0) - MOVE_W'(KEY_STEP);

  // Signed add that clamps to the MOVE_W range instead of wrapping.
  function automatic logic [MOVE_W-1:0] sat_add(input logic [MOVE_W-1:0] a,
                                                input logic [MOVE_W-1:0] b);
    logic [MOVE_W:0] sum;
    sum = {a[MOVE_W-1], a} + {b[MOVE_W-1], b};
    if (sum[MOVE_W] != sum[MOVE_W-1]) begin
      // Overflow: the extra sign bit holds the true sign of the result.
      sat_add = sum[MOVE_W] ? {1'b1, {(MOVE_W-1){1'b0}}} : {1'b0, {(MOVE_W-1){1'b1}}};
    end else begin
      sat_add = sum[MOVE_W-1:0];
    end
  endfunction

  logic       prev_vsync_q;
  logic       tick;
  logic       frame_stb_q;
  logic [7:0] warmup_q, warmup_d;
  logic       warm;

  assign tick = vsync & ~prev_vsync_q;
  assign warm = (warmup_q == 8'd0);

  // Warmup counts down one step per frame tick and then sticks at zero.
  always_comb begin
    warmup_d = warmup_q;
    if (tick && !warm) begin
      warmup_d = warmup_q - 8'd1;
    end
  end

  // Frame edge detection and the shared warmup counter.
  always_ff @(posedge fclk or posedge game_reset) begin
    if (game_reset) begin
      prev_vsync_q <= 1'b1;
      frame_stb_q  <= 1'b0;
      warmup_q     <= 8'(WARMUP_FRAMES);
    end else begin
      prev_vsync_q <= vsync;
      frame_stb_q  <= tick;
      warmup_q     <= warmup_d;
    end
  end

  assign frame_stb = frame_stb_q;

  for (genvar g = 0; g < NUM_BATS; g++) begin : g_bat
    logic [POS_W-1:0]  pos_cur;
    logic [POS_W-1:0]  diff;
    logic [MOVE_W-1:0] delta;
    logic [MOVE_W-1:0] acc_sum;
    logic              accept;

    logic [MOVE_W-1:0] acc_q, acc_d;
    logic [POS_W-1:0]  prev_pos_q, prev_pos_d;
    logic [1:0]        held_q, held_d;
    mode_e             mode_q, mode_d;
    logic              human_q, human_d;
    logic [MOVE_W-1:0] move_q, move_d;

    assign pos_cur = pos_val[g*POS_W +: POS_W];
    // Modular difference, so a position wrap reads as a small step.
    assign diff    = pos_cur - prev_pos_q;
    assign delta   = {{(MOVE_W-POS_W){diff[POS_W-1]}}, diff};
    assign acc_sum = sat_add(acc_q, delta);
    assign accept  = pos_stb[g] & warm;

    // Apply key and mouse events, then publish and clear on a frame tick.
    always_comb begin
      acc_d      = acc_q;
      prev_pos_d = prev_pos_q;
      held_d     = held_q;
      mode_d     = mode_q;
      human_d    = human_q;
      move_d     = move_q;

      if (key_stb[g]) begin
        held_d = {key_up[g], key_dn[g]};
        mode_d = ModeKey;
        if (key_up[g] || key_dn[g]) begin
          human_d = 1'b1;
        end
      end

      if (pos_stb[g]) begin
        // Baseline is tracked even in warmup so the first live delta is sane.
        prev_pos_d = pos_cur;
        if (accept) begin
          acc_d   = acc_sum;
          mode_d  = ModeMouse;
          human_d = 1'b1;
        end
      end

      if (tick) begin
        // acc_d already folds in a coincident sample, so nothing is lost.
        if (mode_d == ModeMouse) begin
          move_d = acc_d;
        end else begin
          unique case (held_d)
            2'b10:   move_d = KeyStepPos;
            2'b01:   move_d = KeyStepNeg;
            default: move_d = '0;
          endcase
        end
        acc_d = '0;
      end
    end

    // Per-bat state registers.
    always_ff @(posedge fclk or posedge game_reset) begin
      if (game_reset) begin
        acc_q      <= '0;
        prev_pos_q <= '0;
        held_q     <= 2'b00;
        mode_q     <= ModeKey;
        human_q    <= 1'b0;
        move_q     <= '0;
      end else begin
        acc_q      <= acc_d;
        prev_pos_q <= prev_pos_d;
        held_q     <= held_d;
        mode_q     <= mode_d;
        human_q    <= human_d;
        move_q     <= move_d;
      end
    end

    assign bat_human[g]                = human_q;
    assign bat_move[g*MOVE_W +: MOVE_W] = move_q;
  end

endmodule

// File: tb/tb_bat_input_ctrl.sv
// Directed bench for bat_input_ctrl with hand-computed expected moves.
module tb_bat_input_ctrl;

  logic        fclk;
  logic        game_reset;
  logic        vsync;
  logic [1:0]  key_stb, key_up, key_dn, pos_stb;
  logic [15:0] pos_val;
  logic        frame_stb;
  logic [1:0]  bat_human;
  logic [17:0] bat_move;

  int errors = 0;
  int checks = 0;

  bat_input_ctrl dut (
    .fclk       (fclk),
    .game_reset (game_reset),
    .vsync      (vsync),
    .key_stb    (key_stb),
    .key_up     (key_up),
    .key_dn     (key_dn),
    .pos_stb    (pos_stb),
    .pos_val    (pos_val),
    .frame_stb  (frame_stb),
    .bat_human  (bat_human),
    .bat_move   (bat_move)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge fclk);
  endtask

  // One vsync pulse; checks frame_stb pulses exactly once.
  task automatic frame();
    vsync = 1'b1;
    cyc();
    checks++;
    if (frame_stb !== 1'b1) begin
      errors++;
      $display("FAIL frame_stb_pulse: got %b want 1", frame_stb);
    end
    cyc();
    checks++;
    if (frame_stb !== 1'b0) begin
      errors++;
      $display("FAIL frame_stb_single: got %b want 0", frame_stb);
    end
    vsync = 1'b0;
    cyc();
  endtask

  task automatic key_ev(input int b, input logic up, input logic dn);
    key_stb[b] = 1'b1;
    key_up[b]  = up;
    key_dn[b]  = dn;
    cyc();
    key_stb = '0;
  endtask

  task automatic pos_ev(input int b, input logic [7:0] v);
    pos_stb[b]       = 1'b1;
    pos_val[b*8 +: 8] = v;
    cyc();
    pos_stb = '0;
  endtask

  task automatic do_reset();
    game_reset = 1'b1;
    vsync      = 1'b1;
    cyc();
    cyc();
    game_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc();
    cyc();
    checks++;
    if (frame_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_tick: frame_stb got %b want 0", frame_stb);
    end
    vsync = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) frame();
    checks++;
    if (bat_human !== 2'b00) begin
      errors++;
      $display("FAIL reset_human: got %b want 00", bat_human);
    end
    checks++;
    if (bat_move !== 18'd0) begin
      errors++;
      $display("FAIL reset_move: got %h want 0", bat_move);
    end
  endtask

  // Warmup is 4 frames further on from test_reset; clear it.
  task automatic test_keys();
    for (int i = 0; i < 5; i++) frame();
    key_ev(0, 1'b1, 1'b0);
    frame();
    checks++;
    if (bat_move[8:0] !== 9'd4 || bat_human[0] !== 1'b1) begin
      errors++;
      $display("FAIL key_up: move0 %h human0 %b want 004 1", bat_move[8:0], bat_human[0]);
    end
    key_ev(0, 1'b1, 1'b1);
    frame();
    checks++;
    if (bat_move[8:0] !== 9'd0) begin
      errors++;
      $display("FAIL key_both: move0 got %h want 000", bat_move[8:0]);
    end
    key_ev(0, 1'b0, 1'b1);
    frame();
    checks++;
    if (bat_move[8:0] !== 9'h1FC) begin
      errors++;
      $display("FAIL key_dn: move0 got %h want 1fc", bat_move[8:0]);
    end
    key_ev(0, 1'b0, 1'b0);
    frame();
    checks++;
    if (bat_move[8:0] !== 9'd0 || bat_human[0] !== 1'b1 || bat_human[1] !== 1'b0) begin
      errors++;
      $display("FAIL key_release: move0 %h human %b want 000 01", bat_move[8:0], bat_human);
    end
  endtask

  task automatic test_mouse();
    pos_ev(1, 8'd10);
    frame();
    checks++;
    if (bat_move[17:9] !== 9'd10 || bat_human[1] !== 1'b1) begin
      errors++;
      $display("FAIL mouse_first: move1 %h human1 %b want 00a 1", bat_move[17:9], bat_human[1]);
    end
    pos_ev(1, 8'd15);
    pos_ev(1, 8'd13);
    checks++;
    if (bat_move[17:9] !== 9'd10) begin
      errors++;
      $display("FAIL mouse_hold: move1 got %h want 00a", bat_move[17:9]);
    end
    frame();
    checks++;
    if (bat_move[17:9] !== 9'd3) begin
      errors++;
      $display("FAIL mouse_accum: move1 got %h want 003", bat_move[17:9]);
    end
    frame();
    checks++;
    if (bat_move[17:9] !== 9'd0) begin
      errors++;
      $display("FAIL mouse_clear: move1 got %h want 000", bat_move[17:9]);
    end
  endtask

  task automatic test_wrap();
    pos_ev(1, 8'd250);
    frame();
    pos_ev(1, 8'd5);
    frame();
    checks++;
    if (bat_move[17:9] !== 9'd11) begin
      errors++;
      $display("FAIL wrap_up: move1 got %h want 00b", bat_move[17:9]);
    end
    pos_ev(1, 8'd250);
    frame();
    checks++;
    if (bat_move[17:9] !== 9'h1F5) begin
      errors++;
      $display("FAIL wrap_dn: move1 got %h want 1f5", bat_move[17:9]);
    end
  endtask

  task automatic test_warmup();
    do_reset();
    vsync = 1'b0;
    cyc();
    pos_ev(0, 8'd100);
    pos_ev(0, 8'd120);
    frame();
    checks++;
    if (bat_move !== 18'd0 || bat_human !== 2'b00) begin
      errors++;
      $display("FAIL warmup_ignore: move %h human %b want 0 00", bat_move, bat_human);
    end
    for (int i = 0; i < 6; i++) frame();
    pos_ev(0, 8'd121);
    frame();
    checks++;
    if (bat_move[8:0] !== 9'd1 || bat_human[0] !== 1'b1) begin
      errors++;
      $display("FAIL warmup_after: move0 %h human0 %b want 001 1", bat_move[8:0], bat_human[0]);
    end
  endtask

  task automatic test_saturation();
    // Four +127 steps from baseline 121.
    pos_ev(0, 8'd248);
    pos_ev(0, 8'd119);
    pos_ev(0, 8'd246);
    pos_ev(0, 8'd117);
    frame();
    checks++;
    if (bat_move[8:0] !== 9'h0FF) begin
      errors++;
      $display("FAIL sat_pos: move0 got %h want 0ff", bat_move[8:0]);
    end
    // Four -128 steps from baseline 117.
    pos_ev(0, 8'd245);
    pos_ev(0, 8'd117);
    pos_ev(0, 8'd245);
    pos_ev(0, 8'd117);
    frame();
    checks++;
    if (bat_move[8:0] !== 9'h100) begin
      errors++;
      $display("FAIL sat_neg: move0 got %h want 100", bat_move[8:0]);
    end
  endtask

  task automatic test_back_to_back();
    // +3 in-frame, then +7 arriving on the tick cycle itself.
    pos_ev(0, 8'd120);
    pos_stb[0]   = 1'b1;
    pos_val[7:0] = 8'd127;
    vsync        = 1'b1;
    key_ev(1, 1'b1, 1'b0);
    pos_stb = '0;
    checks++;
    if (bat_move[8:0] !== 9'd10) begin
      errors++;
      $display("FAIL tick_coincident: move0 got %h want 00a", bat_move[8:0]);
    end
    checks++;
    if (bat_move[17:9] !== 9'd4) begin
      errors++;
      $display("FAIL bat1_independent: move1 got %h want 004", bat_move[17:9]);
    end
    cyc();
    vsync = 1'b0;
    cyc();
    frame();
    checks++;
    if (bat_move[8:0] !== 9'd0) begin
      errors++;
      $display("FAIL no_double_count: move0 got %h want 000", bat_move[8:0]);
    end
    // Mouse then key in one frame: key wins since it came last.
    pos_ev(0, 8'd130);
    key_ev(0, 1'b0, 1'b1);
    frame();
    checks++;
    if (bat_move[8:0] !== 9'h1FC) begin
      errors++;
      $display("FAIL key_over_mouse: move0 got %h want 1fc", bat_move[8:0]);
    end
  endtask

  initial begin
    game_reset = 1'b1;
    vsync      = 1'b1;
    key_stb    = '0;
    key_up     = '0;
    key_dn     = '0;
    pos_stb    = '0;
    pos_val    = '0;
    test_reset();
    test_keys();
    test_mouse();
    test_wrap();
    test_warmup();
    test_saturation();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
